// File: rtl/adpll_loop_filter.sv
// rtl/adpll_loop_filter.sv - PI loop filter turning phase-detector counts into a saturated DCO control word.
// Optional lock detector enabled by defining ADPLL_LOOP_FILTER_LOCK_DETECT_EN.
module adpll_loop_filter #(
  parameter int PD_WIDTH    = 5,
  parameter int CTRL_WIDTH  = 10,
  parameter int ACC_WIDTH   = 16,
  parameter int KP_SHIFT    = 2,
  parameter int KI_SHIFT    = 3,
  parameter int CTRL_CENTER = 512,
  parameter int LOCK_THRESH = 1,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic [PD_WIDTH-1:0]   pd_clock_cycles_i,
  input  logic                  pd_sign_i,
  input  logic                  pd_valid_i,
  input  logic                  hold_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic                  ctrl_valid_o,
  output logic                  overrun_o,
  output logic                  locked_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_INTEG  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  // Wide enough that centre + P + I can never wrap before the clamp.
  localparam int SUM_W = ACC_WIDTH + KP_SHIFT + CTRL_WIDTH + 2;

  logic [1:0]                  r_state;
  logic signed [ACC_WIDTH-1:0] r_e;
  logic signed [ACC_WIDTH-1:0] r_integ;
  logic                        r_hold;
  logic [CTRL_WIDTH-1:0]       r_ctrl;
  logic                        r_ctrl_valid;
  logic                        r_overrun;

  logic signed [ACC_WIDTH-1:0] w_mag_ext;
  logic signed [ACC_WIDTH-1:0] w_e_new;
  logic signed [ACC_WIDTH:0]   w_acc_sum;
  logic signed [ACC_WIDTH-1:0] w_integ_next;
  logic signed [SUM_W-1:0]     w_p;
  logic signed [ACC_WIDTH-1:0] w_i_acc;
  logic signed [SUM_W-1:0]     w_sum;
  logic [CTRL_WIDTH-1:0]       w_ctrl_next;

  assign w_mag_ext = $signed({{(ACC_WIDTH-PD_WIDTH){1'b0}}, pd_clock_cycles_i});
  assign w_e_new   = pd_sign_i ? w_mag_ext : -w_mag_ext;
  assign w_acc_sum = {r_integ[ACC_WIDTH-1], r_integ} + {r_e[ACC_WIDTH-1], r_e};

  always_comb begin
    w_integ_next = w_acc_sum[ACC_WIDTH-1:0];
    if (w_acc_sum[ACC_WIDTH] != w_acc_sum[ACC_WIDTH-1]) begin
      w_integ_next = w_acc_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  assign w_p     = {{(SUM_W-ACC_WIDTH){r_e[ACC_WIDTH-1]}}, r_e} <<< KP_SHIFT;
  assign w_i_acc = r_integ >>> KI_SHIFT;
  assign w_sum   = SUM_W'(CTRL_CENTER) + w_p
                 + {{(SUM_W-ACC_WIDTH){w_i_acc[ACC_WIDTH-1]}}, w_i_acc};

  always_comb begin
    w_ctrl_next = w_sum[CTRL_WIDTH-1:0];
    if (w_sum[SUM_W-1]) begin
      w_ctrl_next = '0;
    end else if (|w_sum[SUM_W-2:CTRL_WIDTH]) begin
      w_ctrl_next = '1;
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_e          <= '0;
      r_integ      <= '0;
      r_hold       <= 1'b0;
      r_ctrl       <= CTRL_WIDTH'(CTRL_CENTER);
      r_ctrl_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_ctrl_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pd_valid_i) begin
            r_e     <= w_e_new;
            r_hold  <= hold_i;
            r_state <= S_INTEG;
          end
        end
        S_INTEG: begin
          if (!r_hold) begin
            r_integ <= w_integ_next;
          end
          r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          r_ctrl       <= w_ctrl_next;
          r_ctrl_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Strobes landing mid-computation are dropped, never queued.
      if (pd_valid_i && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef ADPLL_LOOP_FILTER_LOCK_DETECT_EN
  localparam int LC_W = $clog2(LOCK_COUNT + 1);

  logic [LC_W-1:0] r_lock_cnt;
  logic            r_in_thresh;
  logic            r_locked;
  logic [LC_W-1:0] w_lock_cnt_next;

  always_comb begin
    w_lock_cnt_next = r_lock_cnt + 1'b1;
    if (!r_in_thresh) begin
      w_lock_cnt_next = '0;
    end else if (r_lock_cnt == LC_W'(LOCK_COUNT)) begin
      w_lock_cnt_next = r_lock_cnt;
    end
  end

  // Lock state changes together with the ctrl_valid_o strobe.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lock_cnt  <= '0;
      r_in_thresh <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && pd_valid_i) begin
        r_in_thresh <= (pd_clock_cycles_i <= PD_WIDTH'(LOCK_THRESH));
      end
      if (r_state == S_OUTPUT) begin
        r_lock_cnt <= w_lock_cnt_next;
        r_locked   <= (w_lock_cnt_next == LC_W'(LOCK_COUNT));
      end
    end
  end

  assign locked_o = r_locked;
`else
  assign locked_o = 1'b0;
`endif

  assign ctrl_o       = r_ctrl;
  assign ctrl_valid_o = r_ctrl_valid;
  assign overrun_o    = r_overrun;

endmodule
